cbus_arbiter: RTL
=================

# cbus_arbiter

Two-master arbiter sharing the single core memory bus (cbus) between the instruction-fetch port (ibus) and the load/store port (dbus). It sits between the core and the memory/cache interface and owns the whole transaction lifecycle: arbitration, grant hold, response steering, and discard of abandoned fetches after a redirect. Data requests win by default; a starvation counter guarantees fetch progress.

## Interface
- STARVE_LIMIT, 4: consecutive dbus grants allowed while ibus waits before ibus is forced to win; legal range 1..15.
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- ireq  in  ibus_req_t  fetch request {valid, addr[63:0]}.
- iresp  out  ibus_resp_t  {addr_ok, data_ok, data[31:0]}.
- dreq  in  dbus_req_t  data request {valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]}; strobe==0 means read.
- dresp  out  dbus_resp_t  {addr_ok, data_ok, data[63:0]}.
- oreq  out  cbus_req_t  {valid, is_write, size, addr, strobe, data, len, burst}.
- oresp  in  cbus_resp_t  {ready, last, data[63:0]}.

## Operation
- FSM: IDLE, BUSY_I, BUSY_D. Reset and power-up state is IDLE.
- IDLE: if dreq.valid and not (ireq.valid and starve_cnt==STARVE_LIMIT), go to BUSY_D. Else if ireq.valid, go to BUSY_I. Else stay in IDLE.
- The grant is registered. Requester fields are driven to oreq combinationally from the owner, and the requester holds them stable until its data_ok.
- oreq for ibus: is_write=0, size=MSIZE4, addr=ireq.addr, strobe=0, len=MLEN1, burst=AXI_BURST_FIXED.
- oreq for dbus: is_write=(strobe!=0), size/addr/strobe/data copied from dreq, len=MLEN1, burst=AXI_BURST_FIXED.
- Completion is oresp.ready && oresp.last while in BUSY_x. On completion the owner gets addr_ok=data_ok=1 for that cycle, and the FSM returns to IDLE.
- iresp.data = oresp.data[63:32] when the latched addr[2]=1, else [31:0]. dresp.data = oresp.data.
- Abandon: the abandon flag is set if ireq.valid falls while in BUSY_I before completion (redirect). The cbus transaction still runs to completion, with oreq fields held from an internal address/size latch captured at grant. On completion iresp.data_ok is suppressed. The flag clears on exit to IDLE. dbus is never abandoned; dreq.valid falling in BUSY_D is a protocol violation (assert).
- starve_cnt (4 bits):
  - cleared on reset and on every ibus grant;
  - incremented on a dbus grant made while ireq.valid=1;
  - saturates at STARVE_LIMIT;
  - unchanged on a dbus grant with ireq.valid=0.

## Timing
- Reset values: oreq.valid=0, all oreq fields 0, iresp/dresp addr_ok/data_ok=0, data=0, starve_cnt=0, abandon=0, state IDLE.
- rst asserted mid-transaction forces IDLE on the next edge, and oreq.valid drops that same edge. Any late oresp.ready after that is ignored in IDLE.
- Request at cycle 0 in IDLE: grant registered at edge 0→1, and oreq.valid=1 from cycle 1.
- With oresp.ready at cycle k, data_ok is asserted in cycle k (combinational from oresp). IDLE at k+1; the next grant is registered at k+1 and oreq.valid is high at k+2.
- Minimum transaction is 2 cycles (1 arbitration bubble + 1 beat).
- oreq.valid is never high in IDLE. At most one of iresp.data_ok/dresp.data_ok is high in any cycle.
- Simultaneous ireq.valid and dreq.valid in IDLE: dbus wins unless starve_cnt==STARVE_LIMIT.
- oresp.ready && !last: stay in BUSY_x; no data_ok.

## Structure
- common package holds:
  - ibus/dbus/cbus req/resp typedefs;
  - MSIZE*, MLEN1, AXI_BURST_FIXED constants;
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D}.
- One sub-module, arb_starve_cnt: the saturating counter plus the force-ibus compare, parameterized by STARVE_LIMIT.
- Everything else is a single always_ff FSM plus combinational mux/steering in cbus_arbiter.

## Test plan
- Lone fetch: ireq addr=0x8000_0004, oresp.ready at cycle 3 with data=0xAAAA_BBBB_1111_2222. Expect oreq.valid cycles 1–3, iresp.data_ok at cycle 3 with data=0xAAAA_BBBB, FSM IDLE at cycle 4.
- Contention: ireq and dreq (store, strobe=0xFF, addr=0x8000_1000) both valid at cycle 0, memory ready after 1 cycle. Expect the dbus beat first with is_write=1, then the ibus grant; starve_cnt goes 0→1→0.
- Starvation: dreq continuously valid with ireq valid, STARVE_LIMIT=4. Expect exactly 4 dbus grants, then an ibus grant, then dbus again.
- Redirect abandon: ireq.valid drops at cycle 2 while BUSY_I, ready at cycle 4. Expect oreq held stable with the original addr through cycle 4, iresp.data_ok=0 throughout, and a new fetch accepted at cycle 5.
- Reset mid-op: rst at cycle 2 of a dbus load. Expect oreq.valid=0 and dresp.data_ok=0 from cycle 3, starve_cnt=0; a ready pulse at cycle 4 produces no response.
- Multi-beat guard: oresp.ready=1, last=0 at cycle 2, then last=1 at cycle 3. Expect data_ok only at cycle 3.

Source files
------------

// File: rtl/cbus_arbiter_pkg.sv
// Shared types and constants for the ibus/dbus -> cbus arbiter.
// Request/response structs mirror the core-side ports and the memory-side cbus.
package cbus_arbiter_pkg;

    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;
    localparam logic [2:0] MSIZE8 = 3'd3;
    localparam logic [7:0] MLEN1  = 8'd0;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundle of core-side (ibus/dbus) and memory-side (cbus) channels.
// The arbiter takes the slave view; the core/memory environment takes master.
interface cbus_arbiter_if;
    import cbus_arbiter_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    modport slave  (input ireq, dreq, oresp, output iresp, dresp, oreq);
    modport master (output ireq, dreq, oresp, input iresp, dresp, oreq);
endinterface

// File: rtl/arb_starve_cnt.sv
// Counts dbus grants that bypassed a waiting fetch; once the count reaches
// STARVE_LIMIT the next arbitration is forced to the ibus.
module arb_starve_cnt #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ireq_valid,
    input  logic grant_ibus,
    input  logic grant_dbus,
    output logic force_ibus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (grant_ibus)
            cnt_d = '0;
        else if (grant_dbus && ireq_valid && cnt_q != LIMIT)
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign force_ibus = ireq_valid && (cnt_q == LIMIT);

endmodule

// File: rtl/cbus_arbiter.sv
// Two-master cbus arbiter: dbus wins by default, starvation counter forces
// fetch progress, and redirected fetches run to completion silently.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    cbus_arbiter_if.slave  bus
);
    arb_state_t  state_q, state_d;
    logic        abandon_q, abandon_d;
    logic [63:0] iaddr_q, iaddr_d;
    logic        grant_ibus, grant_dbus, force_ibus;
    logic        complete, i_gone;

    arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk        (clk),
        .rst        (rst),
        .ireq_valid (bus.ireq.valid),
        .grant_ibus (grant_ibus),
        .grant_dbus (grant_dbus),
        .force_ibus (force_ibus)
    );

    assign complete = (state_q != IDLE) && bus.oresp.ready && bus.oresp.last;
    // Once the fetcher lets go, its port may carry a new address; use the grant latch.
    assign i_gone   = abandon_q || !bus.ireq.valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            abandon_q <= 1'b0;
            iaddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            abandon_q <= abandon_d;
            iaddr_q   <= iaddr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        abandon_d  = abandon_q;
        iaddr_d    = iaddr_q;
        grant_ibus = 1'b0;
        grant_dbus = 1'b0;
        case (state_q)
            IDLE: begin
                abandon_d = 1'b0;
                if (bus.dreq.valid && !force_ibus) begin
                    state_d    = BUSY_D;
                    grant_dbus = 1'b1;
                end else if (bus.ireq.valid) begin
                    state_d    = BUSY_I;
                    grant_ibus = 1'b1;
                    iaddr_d    = bus.ireq.addr;
                end
            end
            BUSY_I: begin
                if (complete) begin
                    state_d   = IDLE;
                    abandon_d = 1'b0;
                end else if (!bus.ireq.valid) begin
                    abandon_d = 1'b1;
                end
            end
            BUSY_D: begin
                if (complete) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.oreq  = '0;
        bus.iresp = '0;
        bus.dresp = '0;
        case (state_q)
            BUSY_I: begin
                bus.oreq.valid     = 1'b1;
                bus.oreq.size      = MSIZE4;
                bus.oreq.addr      = i_gone ? iaddr_q : bus.ireq.addr;
                bus.oreq.len       = MLEN1;
                bus.oreq.burst     = AXI_BURST_FIXED;
                bus.iresp.addr_ok  = complete;
                bus.iresp.data_ok  = complete && !i_gone;
                bus.iresp.data     = iaddr_q[2] ? bus.oresp.data[63:32] : bus.oresp.data[31:0];
            end
            BUSY_D: begin
                bus.oreq.valid     = 1'b1;
                bus.oreq.is_write  = (bus.dreq.strobe != '0);
                bus.oreq.size      = bus.dreq.size;
                bus.oreq.addr      = bus.dreq.addr;
                bus.oreq.strobe    = bus.dreq.strobe;
                bus.oreq.data      = bus.dreq.data;
                bus.oreq.len       = MLEN1;
                bus.oreq.burst     = AXI_BURST_FIXED;
                bus.dresp.addr_ok  = complete;
                bus.dresp.data_ok  = complete;
                bus.dresp.data     = bus.oresp.data;
            end
            default: ;
        endcase
    end

    // Load/store requests cannot be withdrawn once granted.
    a_dreq_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == BUSY_D) |-> bus.dreq.valid);

endmodule
